// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver with a free-running 16x oversampling tick, mid-bit sampling,
// start-bit glitch rejection and stop-bit checking.
module uart_rx_oversampled #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic             sync1;
    logic             sync2;
    logic             sync3;
    logic             rx_s;
    logic             falling;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    logic [1:0]       state;
    logic [3:0]       tick_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;

    // Synchronizer resets to 1 so that releasing reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rx_s    = sync2;
    assign falling = sync3 & ~sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (falling) begin
                        tick_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tick_cnt == 4'd7) begin
                            tick_cnt <= '0;
                            if (!rx_s) begin
                                bit_cnt <= '0;
                                state   <= DATA;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (tick_cnt == 4'd15) begin
                            shift   <= {rx_s, shift[7:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                state <= STOP;
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (tick_cnt == 4'd15) begin
                            if (rx_s) begin
                                rx_data <= shift;
                                rx_done <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled at DIV=10 (one bit = 160 clk).
module tb_uart_rx_oversampled;

    localparam int BIT = 160;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;

    int n_cmp;
    int n_err;

    int          cyc;
    int          done_cnt;
    int          ferr_cnt;
    int          both_high;
    int          wide_done;
    int          busy_at_done;
    int          busy_seen;
    logic        done_prev;
    logic [7:0]  got[$];
    int          done_cyc[$];

    uart_rx_oversampled #(
        .CLK_FREQ(16_000_000),
        .BAUD(100_000),
        .OVERSAMPLE(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .rx_busy(rx_busy),
        .frame_err(frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Outputs are observed on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rx_done) begin
            done_cnt = done_cnt + 1;
            got.push_back(rx_data);
            done_cyc.push_back(cyc);
            if (rx_busy) busy_at_done = busy_at_done + 1;
            if (done_prev) wide_done = wide_done + 1;
        end
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (rx_done && frame_err) both_high = both_high + 1;
        if (rx_busy) busy_seen = 1;
        done_prev = rx_done;
    end

    task automatic clear_mon();
        done_cnt     = 0;
        ferr_cnt     = 0;
        busy_seen    = 0;
        busy_at_done = 0;
        got.delete();
        done_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        idle(BIT);
        for (int unsigned i = 0; i < 8; i++) begin
            rx = b[i];
            idle(BIT);
        end
        rx = stop_bit;
        idle(BIT);
        rx = 1'b1;
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic check_outputs_reset(input string tag);
        n_cmp = n_cmp + 1;
        if (rx_data !== 8'h00 || rx_done !== 1'b0 || rx_busy !== 1'b0 || frame_err !== 1'b0) begin
            n_err = n_err + 1;
            $display("FAIL %s: data=0x%02h done=%b busy=%b ferr=%b, expected 00/0/0/0",
                     tag, rx_data, rx_done, rx_busy, frame_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        idle(5);
        check_outputs_reset("reset_values");
        rst = 1'b0;
        idle(BIT);
        check_outputs_reset("idle_after_reset");
    endtask

    task automatic test_single();
        clear_mon();
        send_byte(8'h72, 1'b1);
        idle(2 * BIT);
        check_int("single_done_count", done_cnt, 1);
        check_byte("single_data", (got.size() > 0) ? got[0] : 8'hxx, 8'h72);
        check_int("single_frame_err", ferr_cnt, 0);
        check_int("single_busy_at_done", busy_at_done, 0);
        check_byte("single_data_held", rx_data, 8'h72);
    endtask

    task automatic test_back_to_back();
        int gap;
        clear_mon();
        send_byte(8'h63, 1'b1);
        send_byte(8'h4D, 1'b1);
        idle(2 * BIT);
        check_int("b2b_done_count", done_cnt, 2);
        check_byte("b2b_first", (got.size() > 0) ? got[0] : 8'hxx, 8'h63);
        check_byte("b2b_second", (got.size() > 1) ? got[1] : 8'hxx, 8'h4D);
        gap = (done_cyc.size() > 1) ? (done_cyc[1] - done_cyc[0]) : 0;
        check_int("b2b_gap_in_range", (gap >= 1590 && gap <= 1610) ? 1 : 0, 1);
        check_int("b2b_frame_err", ferr_cnt, 0);
    endtask

    task automatic test_glitch();
        clear_mon();
        @(negedge clk);
        rx = 1'b0;
        idle(40);
        rx = 1'b1;
        idle(3 * BIT);
        check_int("glitch_busy_seen", busy_seen, 1);
        check_int("glitch_done_count", done_cnt, 0);
        check_int("glitch_frame_err", ferr_cnt, 0);
        check_byte("glitch_data_kept", rx_data, 8'h4D);
        check_int("glitch_busy_final", int'(rx_busy), 0);
    endtask

    task automatic test_frame_error();
        clear_mon();
        send_byte(8'h55, 1'b0);
        rx = 1'b0;
        idle(3 * BIT);
        rx = 1'b1;
        idle(2 * BIT);
        check_int("ferr_count", ferr_cnt, 1);
        check_int("ferr_no_done", done_cnt, 0);
        check_byte("ferr_data_kept", rx_data, 8'h4D);
        check_int("ferr_idle_after_break", int'(rx_busy), 0);
        clear_mon();
        send_byte(8'hA5, 1'b1);
        idle(2 * BIT);
        check_int("ferr_recover_count", done_cnt, 1);
        check_byte("ferr_recover_data", rx_data, 8'hA5);
        check_int("ferr_recover_no_err", ferr_cnt, 0);
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        @(negedge clk);
        rx = 1'b0;
        idle(BIT);
        rx = 1'b1;
        idle(4 * BIT + BIT / 2);
        check_int("mid_busy_before_rst", int'(rx_busy), 1);
        rst = 1'b1;
        #1;
        check_outputs_reset("mid_async_reset");
        idle(20);
        check_outputs_reset("mid_reset_held");
        rst = 1'b0;
        idle(6 * BIT);
        check_int("mid_no_strobe", done_cnt + ferr_cnt, 0);
        send_byte(8'h30, 1'b1);
        idle(2 * BIT);
        check_int("mid_next_count", done_cnt, 1);
        check_byte("mid_next_data", rx_data, 8'h30);
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        cyc          = 0;
        both_high    = 0;
        wide_done    = 0;
        done_prev    = 1'b0;
        rst          = 1'b1;
        rx           = 1'b1;
        clear_mon();

        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_mid_frame();

        check_int("done_and_ferr_overlap", both_high, 0);
        check_int("done_wider_than_1clk", wide_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
